// File: rtl/l1i_refill_axi_bridge.sv
// L1 instruction-cache refill bridge.
// Issues one AXI4 INCR read burst per line request, buffers every beat,
// then replays the whole line to the cache on consecutive cycles.
module l1i_refill_axi_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int AXI_ID     = 0,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    // cache side
    input  logic              I_rreq,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    // AXI read address channel
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    // AXI read data channel
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    // sticky protocol/response error
    output logic              err
);

    localparam int                CNT_W     = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        RCV,
        DLV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nxt_idx;
    logic              at_last;
    logic              beat_ok;
    logic [DATA_W-1:0] line_buf [LINE_WORDS];

    assign ARID    = ID_W'(AXI_ID);
    assign ARLEN   = 4'(LINE_WORDS - 1);
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    assign RREADY  = (state == RCV);
    assign beat_ok = RREADY && RVALID && (RID == ID_W'(AXI_ID));
    assign at_last = (cnt == LAST_IDX);
    assign nxt_idx = cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (I_rreq)            state_nx = AR;
            AR:      if (ARREADY)           state_nx = RCV;
            RCV:     if (beat_ok && at_last) state_nx = DLV;
            DLV:     if (at_last)           state_nx = DONE;
            DONE:    if (!I_rreq)           state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    // Registered outputs, beat/word counter and sticky error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ARADDR  <= '0;
            ARVALID <= 1'b0;
            I_out   <= '0;
            I_wait  <= 1'b1;
            err     <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_rreq) begin
                        ARADDR  <= I_addr & LINE_MASK;
                        ARVALID <= 1'b1;
                    end
                end
                AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                    end
                end
                RCV: begin
                    if (beat_ok) begin
                        if (RRESP != 2'b00)      err <= 1'b1;
                        if (RLAST != at_last)    err <= 1'b1;
                        if (at_last) begin
                            // Word 0 was captured beats ago, so delivery can
                            // start on the very next cycle with no bubble.
                            cnt    <= '0;
                            I_out  <= line_buf[0];
                            I_wait <= 1'b0;
                        end else begin
                            cnt <= nxt_idx;
                        end
                    end
                end
                DLV: begin
                    if (at_last) begin
                        cnt    <= '0;
                        I_wait <= 1'b1;
                    end else begin
                        cnt   <= nxt_idx;
                        I_out <= line_buf[nxt_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer capture (contents need no reset)
    always_ff @(posedge clk) begin
        if (beat_ok) begin
            line_buf[cnt] <= RDATA;
        end
    end

endmodule

// File: tb/tb_l1i_refill_axi_bridge.sv
// Self-checking bench for l1i_refill_axi_bridge: a behavioural AXI slave
// plays queued beats; expected words/err come from the beat list itself.
module tb_l1i_refill_axi_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int AXI_ID = 0;
    localparam int LW     = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              I_rreq = 1'b0;
    logic [ADDR_W-1:0] I_addr = '0;
    logic [DATA_W-1:0] I_out;
    logic              I_wait;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY = 1'b0;
    logic [ID_W-1:0]   RID = '0;
    logic [DATA_W-1:0] RDATA = '0;
    logic [1:0]        RRESP = '0;
    logic              RLAST = 1'b0;
    logic              RVALID = 1'b0;
    logic              RREADY;
    logic              err;

    always #5 clk = ~clk;

    l1i_refill_axi_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .AXI_ID(AXI_ID), .LINE_WORDS(LW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .I_rreq(I_rreq), .I_addr(I_addr), .I_out(I_out), .I_wait(I_wait),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .err(err)
    );

    typedef struct {
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    beat_t beats[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    err_model = 1'b0;
    int    pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // last_mode: 0 normal, 1 extra early RLAST on beat 1, 2 RLAST missing
    task automatic build_beats(input int stray_pos, input int err_idx, input int last_mode);
        beat_t b;
        beats.delete();
        for (int k = 0; k < LW; k++) begin
            if (k == stray_pos) begin
                b.rid  = ID_W'(AXI_ID + 1 + $urandom_range(0, 13));
                b.data = $urandom;
                b.resp = 2'(1 + $urandom_range(0, 2));
                b.last = 1'($urandom_range(0, 1));
                beats.push_back(b);
            end
            b.rid  = ID_W'(AXI_ID);
            b.data = $urandom;
            b.resp = (k == err_idx) ? 2'b10 : 2'b00;
            case (last_mode)
                0:       b.last = (k == LW - 1);
                1:       b.last = (k == 1) || (k == LW - 1);
                default: b.last = 1'b0;
            endcase
            beats.push_back(b);
        end
    endtask

    // vmode: 0 RVALID always, 1 fixed toggle pattern, 2 random
    task automatic refill(input string tag, input logic [ADDR_W-1:0] addr, input int ar_delay,
                          input int vmode, input int hold_extra, input int rst_after,
                          input bit chk_lat);
        logic [DATA_W-1:0] exp_w[LW];
        logic [DATA_W-1:0] got[$];
        logic [ADDR_W-1:0] ar_first = '0;
        int k = 0, cyc = 0, ar_hs = 0, arv_wait = 0, ar_rises = 0, ar_cyc = -1;
        int first_w = -1, last_w = -1, stable_bad = 0, accepted = 0, done_cyc = -1, pi = 0;
        int n_beats;
        bit prev_arv = 1'b0, rcv, vbit;

        // Reference: first LW beats carrying our ID form the line, in order
        foreach (beats[i]) begin
            if (beats[i].rid == ID_W'(AXI_ID) && k < LW) begin
                exp_w[k] = beats[i].data;
                if (beats[i].resp != 2'b00 || beats[i].last != (k == LW - 1)) err_model = 1'b1;
                k++;
            end
        end
        n_beats = beats.size();

        I_addr = addr;
        I_rreq = 1'b1;
        while (cyc < 300) begin
            if (rst_after >= 0 && accepted == rst_after) begin
                rstn = 1'b0;
                #1;
                check({tag, "/rst_arvalid"}, ARVALID, 1'b0);
                check({tag, "/rst_iwait"}, I_wait, 1'b1);
                check({tag, "/rst_err"}, err, 1'b0);
                check({tag, "/rst_rready"}, RREADY, 1'b0);
                err_model = 1'b0;
                RVALID = 1'b0; ARREADY = 1'b0; I_rreq = 1'b0;
                beats.delete();
                @(negedge clk);
                rstn = 1'b1;
                @(negedge clk);
                return;
            end
            // observe this cycle
            if (ARVALID && !prev_arv) begin
                ar_rises++;
                if (ar_cyc < 0) ar_cyc = cyc;
                ar_first = ARADDR;
            end
            if (ARVALID && prev_arv && ARADDR !== ar_first) stable_bad++;
            if (!ARVALID && prev_arv && ar_hs == 0) stable_bad++;
            prev_arv = ARVALID;
            if (!I_wait) begin
                got.push_back(I_out);
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end
            // slave drive
            ARREADY = ARVALID && (arv_wait >= ar_delay);
            if (ARVALID) arv_wait++;
            case (vmode)
                0:       vbit = 1'b1;
                1:       vbit = pat[pi % 7] != 0;
                default: vbit = 1'($urandom_range(0, 1));
            endcase
            if (ar_hs > 0) pi++;
            if (ar_hs > 0 && beats.size() > 0 && vbit) begin
                RVALID = 1'b1;
                RID    = beats[0].rid;
                RDATA  = beats[0].data;
                RRESP  = beats[0].resp;
                RLAST  = beats[0].last;
            end else begin
                RVALID = 1'b0;
                RID    = ID_W'(AXI_ID);
                RDATA  = $urandom;
                RRESP  = 2'($urandom_range(0, 3));
                RLAST  = 1'($urandom_range(0, 1));
            end
            if (ARVALID && ARREADY) ar_hs++;
            rcv = RVALID && RREADY;
            @(posedge clk);
            if (rcv) begin
                void'(beats.pop_front());
                accepted++;
            end
            @(negedge clk);
            cyc++;
            if (got.size() >= LW && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0 && cyc >= done_cyc + hold_extra) break;
        end
        I_rreq = 1'b0; ARREADY = 1'b0; RVALID = 1'b0;

        check({tag, "/timeout"}, done_cyc >= 0, 1'b1);
        check({tag, "/ar_count"}, ar_rises, 1);
        check({tag, "/araddr"}, ar_first, addr & ~ADDR_W'(LW * 4 - 1));
        check({tag, "/ar_stable"}, stable_bad, 0);
        check({tag, "/beats_used"}, accepted, n_beats);
        check({tag, "/nwords"}, got.size(), LW);
        for (int i = 0; i < LW && i < got.size(); i++)
            check($sformatf("%s/word%0d", tag, i), got[i], exp_w[i]);
        check({tag, "/consecutive"}, last_w - first_w, LW - 1);
        check({tag, "/err"}, err, err_model);
        if (chk_lat) begin
            check({tag, "/lat_ar"}, ar_cyc, 1);
            check({tag, "/lat_first"}, first_w, LW + 2);
            check({tag, "/lat_last"}, last_w, 2 * LW + 1);
        end
        // request dropped: no new burst, I_wait stays high
        for (int i = 0; i < 2; i++) begin
            check({tag, "/idle_arvalid"}, ARVALID, 1'b0);
            check({tag, "/idle_iwait"}, I_wait, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/arvalid", ARVALID, 1'b0);
        check("reset/iwait", I_wait, 1'b1);
        check("reset/iout", I_out, '0);
        check("reset/err", err, 1'b0);
        check("reset/rready", RREADY, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // zero-wait with fixed data and static AR fields
        build_beats(-1, -1, 0);
        for (int i = 0; i < LW; i++) beats[i].data = DATA_W'(32'hA0 + i);
        refill("zero_wait", 32'h0000_1238, 0, 0, 0, -1, 1'b1);
        check("arid", ARID, AXI_ID);
        check("arlen", ARLEN, LW - 1);
        check("arsize", ARSIZE, 3'b010);
        check("arburst", ARBURST, 2'b01);

        build_beats(-1, -1, 0);
        refill("ar_stall", $urandom, 5, 1, 0, -1, 1'b0);

        build_beats(2, -1, 0);
        refill("stray", $urandom, 1, 0, 0, -1, 1'b0);

        build_beats(-1, -1, 0);
        refill("done_hold", $urandom, 0, 0, 3, -1, 1'b0);

        build_beats(-1, 2, 0);
        refill("resp_err", $urandom, 0, 0, 0, -1, 1'b0);

        build_beats(-1, -1, 0);
        refill("sticky", $urandom, 2, 2, 0, -1, 1'b0);

        build_beats(-1, -1, 0);
        refill("mid_reset", $urandom, 0, 0, 0, 2, 1'b0);

        build_beats(-1, -1, 0);
        refill("after_reset", $urandom, 0, 0, 0, -1, 1'b1);

        build_beats(-1, -1, 1);
        refill("early_last", $urandom, 0, 2, 0, -1, 1'b0);

        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        err_model = 1'b0;
        @(negedge clk);
        build_beats(-1, -1, 2);
        refill("no_last", $urandom, 1, 0, 0, -1, 1'b0);

        for (int t = 0; t < 12; t++) begin
            build_beats(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LW - 1)) : -1,
                        ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 1)) : -1,
                        ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0);
            refill($sformatf("rand%0d", t), $urandom, int'($urandom_range(0, 3)), 2,
                   int'($urandom_range(0, 2)), -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
